// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // Access size in bytes (1/2/4/8) from the low two funct3 bits
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load extraction/extension and store byte merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_val,
  output logic [63:0] store_word
);

  logic [63:0] shifted;
  logic [7:0]  size_en;
  logic [7:0]  byte_en;
  logic [63:0] bit_en;

  assign shifted = word >> {offset, 3'b000};

  // Byte enables for the access size, before steering to the offset
  always_comb begin
    size_en = 8'h00;
    case (funct3[1:0])
      2'b00:   size_en = 8'h01;
      2'b01:   size_en = 8'h03;
      2'b10:   size_en = 8'h0F;
      default: size_en = 8'hFF;
    endcase
  end

  // Aligned accesses never spill past byte 7, so truncation is harmless
  assign byte_en = size_en << offset;

  for (genvar b = 0; b < 8; b++) begin : g_bit_en
    assign bit_en[8*b +: 8] = {8{byte_en[b]}};
  end

  assign store_word = (word & ~bit_en) | ((wdata << {offset, 3'b000}) & bit_en);

  // Extract the addressed bytes and sign- or zero-extend them
  always_comb begin
    load_val = '0;
    case (funct3)
      LB:      load_val = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_val = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_val = {{32{shifted[31]}}, shifted[31:0]};
      LD:      load_val = shifted;
      LBU:     load_val = {56'd0, shifted[7:0]};
      LHU:     load_val = {48'd0, shifted[15:0]};
      LWU:     load_val = {32'd0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [2:0]  lat_f3;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  logic [63:0] mem [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [63:0]   rd_word;
  logic [63:0]   load_val;
  logic [63:0]   store_word;
  logic [3:0]    size_m1;
  logic          misalign;
  logic          oob;
  logic          illegal;
  logic          err;
  logic          wr_en;

  assign req_ready = (state == IDLE) && rst;

  assign widx     = lat_addr[AW+2:3];
  assign rd_word  = mem[widx];
  assign size_m1  = access_size(lat_f3) - 4'd1;
  assign misalign = |(lat_addr[2:0] & size_m1[2:0]);
  assign oob      = lat_addr >= ADDR_LIMIT;
  assign illegal  = lat_write ? lat_f3[2] : (lat_f3 == 3'b111);
  assign err      = misalign || oob || illegal;
  assign wr_en    = (state == ACCESS) && lat_write && !err;

  dmem_lane_align u_align (
    .funct3     (lat_f3),
    .offset     (lat_addr[2:0]),
    .word       (rd_word),
    .wdata      (lat_wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // Storage array; deliberately not reset, commits on the ACCESS exit edge
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= store_word;
  end

  // Control FSM with request latch and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_rdata <= (err || lat_write) ? 64'd0 : load_val;
          rsp_err   <= err;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int DEPTH = 512;
  localparam int LIMIT = DEPTH * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=2, instance 1: WAIT_CYCLES=0
  logic [1:0]        rv, rw, rrdy, qr, sv, se;
  logic [1:0][2:0]   f3;
  logic [1:0][63:0]  ad, wd, sd;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(qr[0]), .req_write(rw[0]),
    .req_funct3(f3[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .rsp_valid(sv[0]),
    .rsp_ready(rrdy[0]), .rsp_rdata(sd[0]), .rsp_err(se[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(qr[1]), .req_write(rw[1]),
    .req_funct3(f3[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .rsp_valid(sv[1]),
    .rsp_ready(rrdy[1]), .rsp_rdata(sd[1]), .rsp_err(se[1]));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mb [2][LIMIT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int waits(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Reference: byte memory, size from funct3, little-endian assembly
  function automatic void ref_access(input int i, input logic w, input logic [2:0] f,
                                     input logic [63:0] a, input logic [63:0] d,
                                     output logic [63:0] rd, output logic er);
    int sz = 1 << f[1:0];
    logic [63:0] v = 64'd0;
    er = ((a % 64'(sz)) != 0) || (a >= 64'(LIMIT)) || (w && f[2]) || (!w && f == 3'b111);
    rd = 64'd0;
    if (!er) begin
      if (w) begin
        for (int j = 0; j < sz; j++) mb[i][int'(a[11:0]) + j] = d[8*j +: 8];
      end else begin
        for (int j = 0; j < sz; j++) v = v | (64'(mb[i][int'(a[11:0]) + j]) << (8*j));
        if (!f[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        rd = v;
      end
    end
  endfunction

  // One full transaction; starts and ends #1 after a rising edge with the DUT idle
  task automatic txn(input int i, input logic w, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] d, output logic [63:0] rd, output logic er);
    logic [63:0] exp_rd;
    logic        exp_er;
    int          n;
    ref_access(i, w, f, a, d, exp_rd, exp_er);
    rw[i] = w; f3[i] = f; ad[i] = a; wd[i] = d; rv[i] = 1'b1;
    n = 0;
    while (!qr[i] && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) chk("req_ready_timeout", 64'(qr[i]), 64'd1);
    @(posedge clk); #1;
    rv[i] = 1'b0;
    n = 0;
    while (!sv[i] && n < 64) begin @(posedge clk); #1; n++; end
    chk($sformatf("latency%0d", i), 64'(n), 64'(waits(i) + 1));
    rd = sd[i]; er = se[i];
    chk($sformatf("rdata%0d@%h f%0d w%0d", i, a, f, w), rd, exp_rd);
    chk($sformatf("err%0d@%h f%0d w%0d", i, a, f, w), 64'(er), 64'(exp_er));
    @(posedge clk); #1;
    chk("rsp_drop", 64'(sv[i]), 64'd0);
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    int k = $urandom_range(0, 23);
    int wi = (k < 16) ? k : 488 + k;
    if (r == 0) return 64'(LIMIT) + 64'($urandom_range(0, 255));
    if (r == 1) return {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
    return 64'(wi * 8 + int'($urandom_range(0, 7)));
  endfunction

  initial begin
    logic [63:0] rd, e1, e2;
    logic        er, x;
    int          n;

    rv = '0; rw = '0; rrdy = 2'b11; f3 = '0; ad = '0; wd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rsp_valid", 64'(sv[i]), 64'd0);
      chk("rst_rsp_rdata", sd[i], 64'd0);
      chk("rst_rsp_err",   64'(se[i]), 64'd0);
      chk("rst_req_ready", 64'(qr[i]), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Give the exercised region defined contents
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 24; k++)
        txn(i, 1'b1, 3'b011, 64'(((k < 16) ? k : 488 + k) * 8), {$urandom(), $urandom()}, rd, er);

    // Directed: doubleword round trip, byte merge and extension
    txn(0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, rd, er);
    txn(0, 1'b0, 3'b011, 64'h10, 64'h0, rd, er);
    chk("ld_0x10", rd, 64'h8877665544332211);
    txn(0, 1'b1, 3'b000, 64'h13, 64'h1234_5678_9ABC_DEFF, rd, er);
    txn(0, 1'b0, 3'b000, 64'h13, 64'h0, rd, er);
    chk("lb_0x13", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    txn(0, 1'b0, 3'b100, 64'h13, 64'h0, rd, er);
    chk("lbu_0x13", rd, 64'h0000_0000_0000_00FF);
    txn(0, 1'b0, 3'b011, 64'h10, 64'h0, rd, er);
    chk("ld_merged", rd, 64'h8877_6655_FF33_2211);
    txn(0, 1'b0, 3'b010, 64'h12, 64'h0, rd, er);
    chk("lw_misaligned_err", 64'(er), 64'd1);
    chk("lw_misaligned_rdata", rd, 64'd0);
    txn(0, 1'b1, 3'b011, 64'(LIMIT), 64'hDEAD_BEEF_DEAD_BEEF, rd, er);
    chk("sd_oob_err", 64'(er), 64'd1);
    txn(0, 1'b0, 3'b011, 64'h0, 64'h0, rd, er);
    txn(0, 1'b0, 3'b011, 64'(LIMIT - 8), 64'h0, rd, er);

    // Zero-wait build: word sign/zero extension
    txn(1, 1'b1, 3'b010, 64'h10, 64'h0000_0000_8000_0001, rd, er);
    txn(1, 1'b0, 3'b010, 64'h10, 64'h0, rd, er);
    chk("lw_w0", rd, 64'hFFFF_FFFF_8000_0001);
    txn(1, 1'b0, 3'b110, 64'h10, 64'h0, rd, er);
    chk("lwu_w0", rd, 64'h0000_0000_8000_0001);

    // Reset mid-WAIT aborts an uncommitted store
    rw[0] = 1'b1; f3[0] = 3'b011; ad[0] = 64'h18; wd[0] = 64'hCAFE_F00D_CAFE_F00D; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("midrst_rsp_valid", 64'(sv[0]), 64'd0);
      chk("midrst_rsp_rdata", sd[0], 64'd0);
      chk("midrst_req_ready", 64'(qr[0]), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("postrst_req_ready", 64'(qr[0]), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("postrst_no_rsp", 64'(sv[0]), 64'd0);
    end
    txn(0, 1'b0, 3'b011, 64'h18, 64'h0, rd, er);

    // Backpressure with a second request held on req_valid
    ref_access(0, 1'b0, 3'b011, 64'h10, 64'h0, e1, x);
    ref_access(0, 1'b0, 3'b100, 64'h13, 64'h0, e2, x);
    rrdy[0] = 1'b0;
    rw[0] = 1'b0; f3[0] = 3'b011; ad[0] = 64'h10; rv[0] = 1'b1;
    @(posedge clk); #1;
    f3[0] = 3'b100; ad[0] = 64'h13;
    n = 0;
    while (!sv[0] && n < 64) begin @(posedge clk); #1; n++; end
    chk("bp_latency", 64'(n), 64'd3);
    for (int c = 0; c < 6; c++) begin
      chk("bp_valid", 64'(sv[0]), 64'd1);
      chk("bp_rdata", sd[0], e1);
      chk("bp_req_ready", 64'(qr[0]), 64'd0);
      if (c < 5) begin @(posedge clk); #1; end
    end
    rrdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_drop", 64'(sv[0]), 64'd0);
    chk("bp_idle_ready", 64'(qr[0]), 64'd1);
    @(posedge clk); #1;
    chk("bp_second_taken", 64'(qr[0]), 64'd0);
    rv[0] = 1'b0;
    n = 0;
    while (!sv[0] && n < 64) begin @(posedge clk); #1; n++; end
    chk("bp2_latency", 64'(n), 64'd3);
    chk("bp2_rdata", sd[0], e2);
    @(posedge clk); #1;

    // Randomized traffic on both builds
    for (int k = 0; k < 300; k++) begin
      int i = k & 1;
      txn(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_addr(),
          {$urandom(), $urandom()}, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
